// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcodes, FSM encodings and requester IDs.
package alu_share_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ADD = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_op_unit.sv
// Combinational N-bit ALU slice: AND/OR/XOR per bit, ADD modulo 2^N.
module alu_op_unit
   import alu_share_arbiter_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   logic [N-1:0] and_y;
   logic [N-1:0] or_y;
   logic [N-1:0] xor_y;
   logic [N-1:0] add_y;

   assign and_y = a & b;
   assign or_y  = a | b;
   assign xor_y = a ^ b;
   // Carry out is intentionally dropped.
   assign add_y = a + b;

   always_comb begin
      y = '0;
      case (alu_op_e'(op))
         OP_AND:  y = and_y;
         OP_OR:   y = or_y;
         OP_XOR:  y = xor_y;
         OP_ADD:  y = add_y;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one ALU between two valid/ready requesters,
// returning a registered, ID-tagged result.
//
//   state | meaning
//   IDLE  | waiting; grants one valid requester and latches its operation
//   EXEC  | ALU evaluates latched operands; result/ID registered at end
//   RESP  | resp_valid held with stable data until resp_ready
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [1:0]   req0_op,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [1:0]   req1_op,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         req1_ready,
   output logic         resp_valid,
   output logic         resp_id,
   output logic [N-1:0] resp_data,
   input  logic         resp_ready
);

   arb_state_e   state;
   arb_state_e   state_nxt;
   logic         last_grant;
   logic         grant0;
   logic         grant1;
   logic         accept;
   logic [1:0]   lat_op;
   logic [N-1:0] lat_a;
   logic [N-1:0] lat_b;
   logic         lat_id;
   logic [N-1:0] alu_y;

   // Requester 0 wins contention unless it was the last one served.
   assign grant0 = req0_valid && (!req1_valid || (last_grant == REQ_ID1));
   assign grant1 = req1_valid && !grant0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      resp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rst) begin
               req0_ready = grant0;
               req1_ready = grant1;
               accept     = grant0 || grant1;
            end
            if (accept) begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= REQ_ID1;
         lat_op     <= 2'b00;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_id     <= REQ_ID0;
         resp_data  <= '0;
         resp_id    <= REQ_ID0;
      end else begin
         if (accept) begin
            last_grant <= grant1;
            lat_id     <= grant1;
            lat_op     <= grant1 ? req1_op : req0_op;
            lat_a      <= grant1 ? req1_a  : req0_a;
            lat_b      <= grant1 ? req1_b  : req0_b;
         end
         if (state == ST_EXEC) begin
            resp_data <= alu_y;
            resp_id   <= lat_id;
         end
      end
   end

   alu_op_unit #(
      .N (N)
   ) u_alu_op_unit (
      .op (lat_op),
      .a  (lat_a),
      .b  (lat_b),
      .y  (alu_y)
   );

endmodule
